// File: rtl/mem_link_host.sv
// mem_link_host: host-side initiator for the 4-byte UART memory command protocol.
// Accepts one read/write request, sends the header [cmd, count, addr_hi, addr_lo]
// through the UART transmitter, then streams count+1 write bytes out or collects
// count+1 read bytes from the UART receiver.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   start, req_*               request strobe (IDLE only) and request fields
//   wr_data/wr_valid/wr_ready  write payload handshake
//   rd_data/rd_valid           read payload byte and 1-cycle strobe
//   busy, done, timeout        transfer status; timeout qualifies done
//   transmit, tx_byte          1-cycle send strobe and byte to the UART tx
//   is_transmitting            UART tx busy
//   received, rx_byte          1-cycle strobe and byte from the UART rx
module mem_link_host #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_count,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        is_transmitting,
    input  logic        received,
    input  logic [7:0]  rx_byte
);

    typedef enum logic [2:0] {
        StIdle, StHdr, StHdrGap, StWdata, StWdataGap, StRdata, StFin
    } state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] addr_q, addr_d;
    logic [1:0]  hidx_q, hidx_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [31:0] tmo_ctr_q, tmo_ctr_d;
    logic        tmo_q, tmo_d;
    logic        transmit_q, transmit_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  hdr_byte;

    always_comb begin
        hdr_byte = 8'h00;
        case (hidx_q)
            2'd0:    hdr_byte = write_q ? 8'h02 : 8'h01;
            2'd1:    hdr_byte = count_q;
            2'd2:    hdr_byte = addr_q[15:8];
            default: hdr_byte = addr_q[7:0];
        endcase
    end

    assign wr_ready = (state_q == StWdata) && !is_transmitting;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign timeout  = (state_q == StFin) && tmo_q;
    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        count_d     = count_q;
        addr_d      = addr_q;
        hidx_d      = hidx_q;
        remaining_d = remaining_q;
        tmo_ctr_d   = tmo_ctr_q;
        tmo_d       = tmo_q;
        transmit_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    write_d = req_write;
                    count_d = req_count;
                    addr_d  = req_addr;
                    hidx_d  = 2'd0;
                    tmo_d   = 1'b0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (!is_transmitting) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = hdr_byte;
                    state_d    = StHdrGap;
                end
            end
            // The gap cycle ignores is_transmitting: the tx only raises it one
            // cycle after seeing the transmit pulse.
            StHdrGap: begin
                if (hidx_q != 2'd3) begin
                    hidx_d  = hidx_q + 2'd1;
                    state_d = StHdr;
                end else begin
                    remaining_d = count_q;
                    tmo_ctr_d   = 32'd0;
                    state_d     = write_q ? StWdata : StRdata;
                end
            end
            StWdata: begin
                if (wr_valid && wr_ready) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = wr_data;
                    state_d    = StWdataGap;
                end
            end
            StWdataGap: begin
                if (remaining_q == 8'd0) begin
                    state_d = StFin;
                end else begin
                    remaining_d = remaining_q - 8'd1;
                    state_d     = StWdata;
                end
            end
            StRdata: begin
                if (received) begin
                    rd_data_d  = rx_byte;
                    rd_valid_d = 1'b1;
                    tmo_ctr_d  = 32'd0;
                    if (remaining_q == 8'd0) begin
                        state_d = StFin;
                    end else begin
                        remaining_d = remaining_q - 8'd1;
                    end
                end else if (tmo_ctr_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    tmo_ctr_d = tmo_ctr_q + 32'd1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            count_q     <= 8'd0;
            addr_q      <= 16'd0;
            hidx_q      <= 2'd0;
            remaining_q <= 8'd0;
            tmo_ctr_q   <= 32'd0;
            tmo_q       <= 1'b0;
            transmit_q  <= 1'b0;
            tx_byte_q   <= 8'd0;
            rd_data_q   <= 8'd0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            hidx_q      <= hidx_d;
            remaining_q <= remaining_d;
            tmo_ctr_q   <= tmo_ctr_d;
            tmo_q       <= tmo_d;
            transmit_q  <= transmit_d;
            tx_byte_q   <= tx_byte_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_mem_link_host.sv
// Self-checking bench for mem_link_host: table of read/write transfers plus
// hand-written sequences for stray bytes, start-while-busy and mid-transfer reset.
module tb_mem_link_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_count;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_transmitting = 1'b0;
    logic        received;
    logic [7:0]  rx_byte;

    mem_link_host #(.TIMEOUT_CYCLES(100)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_count      (req_count),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .is_transmitting(is_transmitting),
        .received       (received),
        .rx_byte        (rx_byte)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor and UART tx model, evaluated 2ns after each rising edge.
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    int cyc = 0;
    int last_tx_cyc = 0;
    bit have_last = 0;
    bit tx_pend = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    bit done_to = 0;
    int done_cyc = 0;
    int last_rdv_cyc = 0;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (reset) begin
            tx_pend = 0;
            tx_cnt = 0;
            is_transmitting = 1'b0;
            have_last = 0;
        end else begin
            if (transmit) begin
                tx_q.push_back(tx_byte);
                if (have_last) chk("tx_spacing", 32'(cyc - last_tx_cyc >= 52), 1);
                have_last = 1;
                last_tx_cyc = cyc;
            end
            if (rd_valid) begin
                rd_q.push_back(rd_data);
                last_rdv_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_to = timeout;
                done_cyc = cyc;
            end
            if (is_transmitting) chk("wr_ready_while_tx_busy", 32'(wr_ready), 0);
            // tx raises busy the cycle after a transmit pulse and holds it 50 cycles
            if (tx_pend) begin
                tx_cnt = 50;
                tx_pend = 0;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
            end
            if (transmit) tx_pend = 1;
            is_transmitting = (tx_cnt != 0);
        end
    end

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  cnt;
        logic [31:0] data;
        int          n_rx;
        bit          stall;
        logic [31:0] exp_hdr;
        int          exp_n;
        bit          exp_to;
    } vec_t;

    vec_t vecs[5];

    task automatic offer_byte(input logic [7:0] d);
        int w = 0;
        wr_data = d;
        wr_valid = 1'b1;
        while (!wr_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("wr_ready_wait", 32'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d);
        rx_byte = d;
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_hdr();
        int w = 0;
        while (tx_q.size() < 4 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("hdr_sent", 32'(tx_q.size() >= 4), 1);
    endtask

    task automatic wait_done();
        int w = 0;
        while (done_cnt == 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", 32'(done_cnt != 0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input bit wr, input logic [15:0] addr, input logic [7:0] cnt);
        tx_q.delete();
        rd_q.delete();
        done_cnt = 0;
        req_write = wr;
        req_addr = addr;
        req_count = cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        issue(v.wr, v.addr, v.cnt);
        if (v.wr) begin
            for (int i = 0; i <= int'(v.cnt); i++) begin
                if (v.stall) repeat (80) @(negedge clk);
                offer_byte(v.data[31-8*i -: 8]);
            end
        end else begin
            wait_hdr();
            repeat (60) @(negedge clk);
            for (int i = 0; i < v.n_rx; i++) send_rx(v.data[31-8*i -: 8]);
        end
        wait_done();
        for (int i = 0; i < 4; i++)
            chk($sformatf("v%0d_hdr%0d", idx, i), 32'(tx_q[i]), 32'(v.exp_hdr[31-8*i -: 8]));
        if (v.wr) begin
            chk($sformatf("v%0d_tx_count", idx), tx_q.size(), 4 + v.exp_n);
            for (int i = 0; i < v.exp_n; i++)
                chk($sformatf("v%0d_wdata%0d", idx, i), 32'(tx_q[4+i]),
                    32'(v.data[31-8*i -: 8]));
        end else begin
            chk($sformatf("v%0d_tx_count", idx), tx_q.size(), 4);
            chk($sformatf("v%0d_rd_count", idx), rd_q.size(), v.exp_n);
            for (int i = 0; i < v.exp_n; i++)
                chk($sformatf("v%0d_rdata%0d", idx, i), 32'(rd_q[i]),
                    32'(v.data[31-8*i -: 8]));
        end
        chk($sformatf("v%0d_done_count", idx), done_cnt, 1);
        chk($sformatf("v%0d_timeout", idx), 32'(done_to), 32'(v.exp_to));
        if (v.exp_to) chk($sformatf("v%0d_timeout_delay", idx), done_cyc - last_rdv_cyc, 100);
        chk($sformatf("v%0d_busy_after", idx), 32'(busy), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_transmit"}, 32'(transmit), 0);
        chk({tag, "_tx_byte"}, 32'(tx_byte), 0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    initial begin
        //            wr    addr      cnt   data          n_rx stall hdr           n  to
        vecs[0] = '{1'b0, 16'h1234, 8'd0, 32'hAB000000, 1, 1'b0, 32'h01001234, 1, 1'b0};
        vecs[1] = '{1'b1, 16'h0010, 8'd2, 32'h11223300, 0, 1'b0, 32'h02020010, 3, 1'b0};
        vecs[2] = '{1'b0, 16'hBEEF, 8'd3, 32'h5AA500FF, 4, 1'b0, 32'h0103BEEF, 4, 1'b0};
        vecs[3] = '{1'b1, 16'hFF00, 8'd0, 32'hC3000000, 0, 1'b1, 32'h0200FF00, 1, 1'b0};
        vecs[4] = '{1'b0, 16'h0007, 8'd3, 32'h66770000, 2, 1'b0, 32'h01030007, 2, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        req_write = 1'b0;
        req_addr = 16'h0;
        req_count = 8'h0;
        wr_data = 8'h0;
        wr_valid = 1'b0;
        received = 1'b0;
        rx_byte = 8'h0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Stray rx byte during the header plus a start pulse while busy.
        issue(1'b0, 16'h4000, 8'd0);
        begin
            int w = 0;
            while (tx_q.size() < 1 && w < 3000) begin
                @(negedge clk);
                w++;
            end
        end
        rx_byte = 8'hFF;
        received = 1'b1;
        start = 1'b1;
        req_write = 1'b1;
        @(negedge clk);
        received = 1'b0;
        start = 1'b0;
        req_write = 1'b0;
        wait_hdr();
        repeat (10) @(negedge clk);
        send_rx(8'h5E);
        wait_done();
        chk("stray_hdr0", 32'(tx_q[0]), 32'h01);
        chk("stray_hdr2", 32'(tx_q[2]), 32'h40);
        chk("stray_rd_count", rd_q.size(), 1);
        chk("stray_rd_data", 32'(rd_q[0]), 32'h5E);
        repeat (150) @(negedge clk);
        chk("no_second_xfer_tx", tx_q.size(), 4);
        chk("no_second_xfer_done", done_cnt, 1);
        chk("no_second_xfer_busy", 32'(busy), 0);

        // Reset in the middle of a 256-byte write.
        issue(1'b1, 16'h2000, 8'd255);
        for (int i = 0; i < 3; i++) offer_byte(8'(8'h90 + i));
        begin
            int w = 0;
            while (!wr_ready && w < 3000) begin
                @(negedge clk);
                w++;
            end
            chk("midreset_in_wdata", 32'(wr_ready), 1);
        end
        chk("midreset_tx_before", tx_q.size(), 7);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midreset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset_no_done", done_cnt, 0);
        run_vec(vecs[0], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
